gain_curve_reader: RTL

- Streams a contiguous window of the stored gain curve out of the read-only port of the dual-port gain-curve RAM, one sample per clock, to the FFT-bin multiplier.
- Generates the RAM read addresses and absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer.
- Presents a valid/ready stream with last-beat marking and supports full backpressure.

---
 rtl/gain_curve_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gain_curve_reader.sv
// Gain-curve window reader: issues sequential RAM reads for a burst and streams
// the samples out through a 2-entry buffer that hides the 1-cycle RAM latency.
module gain_curve_reader #(
   parameter int unsigned LOGSIZE = 13,
   parameter int unsigned WIDTH   = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [LOGSIZE-1:0] base_addr,
   input  logic [LOGSIZE:0]   count,
   output logic [LOGSIZE-1:0] ram_addr,
   input  logic [WIDTH-1:0]   ram_dout,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   output logic               busy,
   output logic               done
);

   localparam logic [LOGSIZE:0] CNT_ONE = {{LOGSIZE{1'b0}}, 1'b1};
   localparam logic [LOGSIZE:0] CNT_MAX = {1'b1, {LOGSIZE{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [LOGSIZE-1:0] addr_q, addr_d;
   logic [LOGSIZE:0]   issue_rem_q, issue_rem_d;
   logic [LOGSIZE:0]   beat_rem_q, beat_rem_d;
   logic               inflight_q, inflight_d;
   logic               inflight_last_q, inflight_last_d;
   logic [WIDTH-1:0]   buf_data_q [2];
   logic [WIDTH-1:0]   buf_data_d [2];
   logic               buf_last_q [2];
   logic               buf_last_d [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         occ_q, occ_d;
   logic               done_q, done_d;

   logic               pop;
   logic               issue;
   logic               issue_last;
   logic [1:0]         slots_used;
   logic [LOGSIZE:0]   count_sat;

   assign m_valid  = (occ_q != 2'd0);
   assign m_data   = buf_data_q[rd_ptr_q];
   assign m_last   = m_valid & buf_last_q[rd_ptr_q];
   assign ram_addr = addr_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

   // A read may issue only if the entry it produces fits after this cycle's pop.
   assign pop        = m_valid & m_ready;
   assign slots_used = occ_q + {1'b0, inflight_q} - {1'b0, pop};
   assign issue      = (state_q == S_RUN) && (issue_rem_q != '0) && (slots_used < 2'd2);
   assign issue_last = issue && (issue_rem_q == CNT_ONE);
   assign count_sat  = (count > CNT_MAX) ? CNT_MAX : count;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      issue_rem_d     = issue_rem_q;
      beat_rem_d      = beat_rem_q;
      inflight_d      = issue;
      inflight_last_d = issue_last;
      buf_data_d      = buf_data_q;
      buf_last_d      = buf_last_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      occ_d           = slots_used;
      done_d          = 1'b0;

      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         beat_rem_d = beat_rem_q - 1'b1;
      end

      if (inflight_q) begin
         buf_data_d[wr_ptr_q] = ram_dout;
         buf_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d             = ~wr_ptr_q;
      end

      // The final read leaves ram_addr parked on the last address.
      if (issue) begin
         issue_rem_d = issue_rem_q - 1'b1;
         if (!issue_last) begin
            addr_d = addr_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               issue_rem_d = count_sat;
               beat_rem_d  = count_sat;
               state_d     = (count_sat == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (issue_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((beat_rem_q == '0) || (pop && m_last)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d         = S_IDLE;
         addr_d          = addr_q;
         issue_rem_d     = '0;
         beat_rem_d      = '0;
         inflight_d      = 1'b0;
         inflight_last_d = 1'b0;
         rd_ptr_d        = 1'b0;
         wr_ptr_d        = 1'b0;
         occ_d           = 2'd0;
         done_d          = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         issue_rem_q     <= '0;
         beat_rem_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            buf_data_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         occ_q           <= 2'd0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         issue_rem_q     <= issue_rem_d;
         beat_rem_q      <= beat_rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         buf_data_q      <= buf_data_d;
         buf_last_q      <= buf_last_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         occ_q           <= occ_d;
         done_q          <= done_d;
      end
   end

endmodule
